// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, fault causes and address-to-index helpers for imem_fetch_port
package imem_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_RANGE,
    FAULT_ALIGN,
    FAULT_PARITY
  } fault_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  // Addresses are widened to 64 bits so the range check never wraps.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic byte_addr,
                                             input int unsigned lsb_w);
    return byte_addr ? (addr >> lsb_w) : addr;
  endfunction

  function automatic fault_e addr_fault(input logic [63:0] addr, input logic byte_addr,
                                        input int unsigned lsb_w, input int unsigned depth);
    logic [63:0] lsb_mask;
    lsb_mask = (64'd1 << lsb_w) - 64'd1;
    if (byte_addr && ((addr & lsb_mask) != 64'd0))
      return FAULT_ALIGN;
    else if (word_index(addr, byte_addr, lsb_w) >= 64'(depth))
      return FAULT_RANGE;
    else
      return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - synchronous read-first storage, one read port and one write port
module imem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Both blocks sample mem before the edge, so a same-word write is seen by the next read only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory with valid/ready fetch port, flush and load port
// Defining IMEM_PARITY_EN adds per-word even parity and the par_inject test input.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter int BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
`ifdef IMEM_PARITY_EN
  input  logic              par_inject,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int LSB_W = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic BYTE_MODE = (BYTE_ADDR != 0);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e           state;
  fault_e           fault_q;
  fault_e           req_fault;
  fault_e           wr_fault;
  logic             accept;
  logic             par_err;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_rdata;

  assign req_fault = addr_fault(64'(req_addr), BYTE_MODE, LSB_W, DEPTH);
  assign wr_fault  = addr_fault(64'(wr_addr), BYTE_MODE, LSB_W, DEPTH);
  // Truncation to the array index happens only after the full-width range check above.
  assign rd_idx    = IDX_W'(word_index(64'(req_addr), BYTE_MODE, LSB_W));
  assign wr_idx    = IDX_W'(word_index(64'(wr_addr), BYTE_MODE, LSB_W));

  assign req_ready = !rst && !flush && (state == ST_EMPTY || rsp_ready);
  assign accept    = req_valid && req_ready;

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {(^wr_data) ^ par_inject, wr_data};
  assign par_err   = (fault_q == FAULT_NONE) && (^ram_rdata);
`else
  assign ram_wdata = wr_data;
  assign par_err   = 1'b0;
`endif

  imem_ram #(
    .WIDTH(RAM_W),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (accept && req_fault == FAULT_NONE),
    .rd_idx (rd_idx),
    .rd_data(ram_rdata),
    .wr_en  (wr_en && wr_fault == FAULT_NONE),
    .wr_idx (wr_idx),
    .wr_data(ram_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      fault_q   <= FAULT_NONE;
    end else if (flush) begin
      state     <= ST_EMPTY;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      state     <= ST_FULL;
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      fault_q   <= req_fault;
    end else if (state == ST_FULL && rsp_ready) begin
      state     <= ST_EMPTY;
      rsp_valid <= 1'b0;
    end
  end

  // The RAM read register is the instruction half of the output register; faults mask it.
  assign rsp_err  = (fault_q != FAULT_NONE) || par_err;
  assign rsp_inst = rsp_err ? NOP_WORD : ram_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - directed and randomized checks of imem_fetch_port against a reference model
module tb_imem_fetch_port;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush, wr_en;
  logic [31:0] req_addr, rsp_inst, rsp_addr, wr_addr, wr_data;
  logic        par_inject;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_bad [DEPTH];
  bit          m_valid, m_err;
  logic [31:0] m_inst, m_addr;

  always #5 clk = ~clk;

  imem_fetch_port #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(1), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .flush(flush),
`ifdef IMEM_PARITY_EN
    .par_inject(par_inject),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  function automatic bit addr_ok(logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'(4 * $urandom_range(0, DEPTH - 1));
    if (r == 7) return 32'($urandom_range(0, 255));
    if (r == 8) return 32'(4 * DEPTH + 4 * $urandom_range(0, DEPTH - 1));
    return $urandom;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check req_ready, advance the model across the edge, check outputs.
  task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                      input bit we, input logic [31:0] wa, input logic [31:0] wd, input bit inj);
    bit exp_ready, acc;
    req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
    wr_en = we; wr_addr = wa; wr_data = wd; par_inject = inj;
    #2;
    exp_ready = !fl && (!m_valid || rr);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    acc = rv && exp_ready;
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_addr  = ra;
      m_err   = !addr_ok(ra) || (PAR && m_bad[ra / 4]);
      m_inst  = m_err ? NOP : m_mem[ra / 4];
    end else if (m_valid && rr) m_valid = 0;
    if (we && addr_ok(wa)) begin
      m_mem[wa / 4] = wd;
      m_bad[wa / 4] = PAR && inj;
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_inst", 64'(rsp_inst), 64'(m_inst));
      chk("rsp_addr", 64'(rsp_addr), 64'(m_addr));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 0, rr, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_inst"}, 64'(rsp_inst), 0);
    chk({tag, "_addr"}, 64'(rsp_addr), 0);
    chk({tag, "_err"}, 64'(rsp_err), 0);
    chk({tag, "_ready"}, 64'(req_ready), 0);
  endtask

  initial begin
    logic [31:0] init_words [4];
    init_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1; req_valid = 1; req_addr = 0; rsp_ready = 1; flush = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; par_inject = 0;
    m_valid = 0; m_err = 0; m_inst = 0; m_addr = 0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 1, 0, 1, 32'(4 * i), (i < 4) ? init_words[i] : $urandom, 0);

    // Back-to-back fetches, one response per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(4 * i), 1, 0, 0, 0, 0, 0);
      chk("b2b_inst", 64'(rsp_inst), 64'(init_words[i]));
    end
    idle(1);

    // Back-pressure holds the response; release accepts the next request in the same cycle.
    step(1, 4, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8, 0, 0, 0, 0, 0, 0);
      chk("hold_inst", 64'(rsp_inst), 64'h22);
      chk("hold_addr", 64'(rsp_addr), 64'd4);
    end
    step(1, 8, 1, 0, 0, 0, 0, 0);
    chk("release_inst", 64'(rsp_inst), 64'h33);
    idle(1);

    // Address faults and an ignored out-of-range write that would alias word 0 if wrapped.
    step(1, 256, 1, 0, 0, 0, 0, 0);
    chk("range_err", 64'(rsp_err), 1);
    chk("range_nop", 64'(rsp_inst), 64'(NOP));
    step(1, 6, 1, 0, 1, 256, 32'hDEAD_BEEF, 0);
    chk("align_err", 64'(rsp_err), 1);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("no_wrap_inst", 64'(rsp_inst), 64'h11);
    step(1, 32'hFFFF_FF00, 1, 0, 0, 0, 0, 0);
    chk("huge_err", 64'(rsp_err), 1);

    // Read-first collision.
    step(1, 8, 1, 0, 1, 8, 32'hAA, 0);
    chk("rf_old", 64'(rsp_inst), 64'h33);
    step(1, 8, 1, 0, 0, 0, 0, 0);
    chk("rf_new", 64'(rsp_inst), 64'hAA);
    idle(1);

    // Flush while FULL blocks the request and clears the response.
    step(1, 4, 0, 0, 0, 0, 0, 0);
    step(1, 8, 1, 1, 0, 0, 0, 0);
    chk("flush_valid", 64'(rsp_valid), 0);
    idle(1);

    // Asynchronous reset mid-transaction.
    step(1, 12, 0, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    check_reset_outputs("async_rst");
    m_valid = 0;
    @(posedge clk); #1;
    rst = 0; req_valid = 0;
    idle(1);
    idle(1);

    if (PAR) begin
      step(0, 0, 1, 0, 1, 20, 32'h5555_0001, 1);
      step(1, 20, 1, 0, 0, 0, 0, 0);
      chk("par_err", 64'(rsp_err), 1);
      chk("par_nop", 64'(rsp_inst), 64'(NOP));
      step(0, 0, 1, 0, 1, 20, 32'h5555_0001, 0);
      step(1, 20, 1, 0, 0, 0, 0, 0);
      chk("par_clear", 64'(rsp_err), 0);
      idle(1);
    end

    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, pick_addr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, pick_addr(), $urandom,
           PAR && ($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
